// File: rtl/conv_sequencer.sv
// Autonomous instruction sequencer for the 2D systolic core: walks one 3x3 convolution
// layer (weight load, activation execute, psum drain per kij, then pmem accumulation).
module conv_sequencer #(
    parameter int COL      = 8,
    parameter int ROW      = 8,
    parameter int LEN_KIJ  = 9,
    parameter int LEN_NIJ  = 36,
    parameter int LEN_ONIJ = 16,
    parameter int KI_W     = 3,
    parameter int IN_W     = 6,
    parameter int OUT_W    = 4,
    parameter int W_BASE   = 128,
    parameter int DRAIN    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
    // Drain must cover the full array pipeline, so never shorter than row+col.
    localparam int DRAIN_CYC = (DRAIN > ROW + COL) ? DRAIN : ROW + COL;

    typedef enum logic [3:0] {
        S_IDLE, S_W_RD, S_W_LD, S_W_DR, S_X_RD, S_X_EX, S_X_DR, S_PS_WR, S_ACC, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_kij, w_kij_nxt;
    logic [3:0]  r_k, w_k_nxt, r_kx, w_kx_nxt, r_ky, w_ky_nxt;
    logic [3:0]  r_ox, w_ox_nxt, r_oy, w_oy_nxt;
    logic [4:0]  r_o, w_o_nxt;
    logic [33:0] r_inst, w_inst;
    logic        r_busy, w_busy, r_done, w_done;
    logic [3:0]  r_kij_idx, w_kij_idx;
    logic        w_acc, w_cen_p, w_wen_p, w_cen_x, w_wen_x;
    logic [10:0] w_a_p, w_a_x;
    logic        w_ofifo_rd, w_l0_rd, w_l0_wr, w_exec, w_load;

    // Next-state, counter and instruction-field decode for the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kij_nxt   = r_kij;
        w_k_nxt     = r_k;
        w_kx_nxt    = r_kx;
        w_ky_nxt    = r_ky;
        w_o_nxt     = r_o;
        w_ox_nxt    = r_ox;
        w_oy_nxt    = r_oy;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_kij_idx   = r_kij;
        w_acc       = 1'b0;
        w_cen_p     = 1'b1;
        w_wen_p     = 1'b1;
        w_a_p       = 11'd0;
        w_cen_x     = 1'b1;
        w_wen_x     = 1'b1;
        w_a_x       = 11'd0;
        w_ofifo_rd  = 1'b0;
        w_l0_rd     = 1'b0;
        w_l0_wr     = 1'b0;
        w_exec      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_W_RD;
                    w_cnt_nxt   = 6'd0;
                    w_kij_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_W_RD: begin
                // l0_wr trails the xmem read by one cycle to absorb SRAM read latency.
                if (r_cnt < 6'(COL)) begin
                    w_cen_x = 1'b0;
                    w_a_x   = 11'(W_BASE) + 11'(r_kij) * 11'(COL) + 11'(r_cnt);
                end else begin
                    w_cen_x = 1'b1;
                end
                w_l0_wr = (r_cnt != 6'd0);
                if (r_cnt == 6'(COL)) begin
                    w_state_nxt = S_W_LD;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_W_LD: begin
                w_l0_rd = 1'b1;
                w_load  = 1'b1;
                if (r_cnt == 6'(COL - 1)) begin
                    w_state_nxt = S_W_DR;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_W_DR: begin
                if (r_cnt == 6'(DRAIN_CYC - 1)) begin
                    w_state_nxt = S_X_RD;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_X_RD: begin
                if (r_cnt < 6'(LEN_NIJ)) begin
                    w_cen_x = 1'b0;
                    w_a_x   = 11'(r_cnt);
                end else begin
                    w_cen_x = 1'b1;
                end
                w_l0_wr = (r_cnt != 6'd0);
                if (r_cnt == 6'(LEN_NIJ)) begin
                    w_state_nxt = S_X_EX;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_X_EX: begin
                w_l0_rd = 1'b1;
                w_exec  = 1'b1;
                if (r_cnt == 6'(LEN_NIJ - 1)) begin
                    w_state_nxt = S_X_DR;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_X_DR: begin
                if (r_cnt == 6'(DRAIN_CYC - 1)) begin
                    w_state_nxt = S_PS_WR;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_PS_WR: begin
                if (valid) begin
                    w_ofifo_rd = 1'b1;
                    w_cen_p    = 1'b0;
                    w_wen_p    = 1'b0;
                    w_a_p      = 11'(r_kij) * 11'(LEN_NIJ) + 11'(r_cnt);
                    if (r_cnt == 6'(LEN_NIJ - 1)) begin
                        w_cnt_nxt = 6'd0;
                        if (r_kij < 4'(LEN_KIJ - 1)) begin
                            w_state_nxt = S_W_RD;
                            w_kij_nxt   = r_kij + 4'd1;
                        end else begin
                            w_state_nxt = S_ACC;
                            w_k_nxt     = 4'd0;
                            w_kx_nxt    = 4'd0;
                            w_ky_nxt    = 4'd0;
                            w_o_nxt     = 5'd0;
                            w_ox_nxt    = 4'd0;
                            w_oy_nxt    = 4'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            S_ACC: begin
                // k == LEN_KIJ is the idle gap that marks an output-pixel boundary.
                if (r_k == 4'(LEN_KIJ)) begin
                    w_k_nxt  = 4'd0;
                    w_kx_nxt = 4'd0;
                    w_ky_nxt = 4'd0;
                    if (r_o == 5'(LEN_ONIJ - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_o_nxt = r_o + 5'd1;
                        if (r_ox == 4'(OUT_W - 1)) begin
                            w_ox_nxt = 4'd0;
                            w_oy_nxt = r_oy + 4'd1;
                        end else begin
                            w_ox_nxt = r_ox + 4'd1;
                        end
                    end
                end else begin
                    w_acc   = 1'b1;
                    w_cen_p = 1'b0;
                    w_a_p   = 11'(r_k) * 11'(LEN_NIJ) + 11'(r_oy) * 11'(IN_W) + 11'(r_ox)
                            + 11'(r_ky) * 11'(IN_W) + 11'(r_kx);
                    w_k_nxt = r_k + 4'd1;
                    if (r_kx == 4'(KI_W - 1)) begin
                        w_kx_nxt = 4'd0;
                        w_ky_nxt = r_ky + 4'd1;
                    end else begin
                        w_kx_nxt = r_kx + 4'd1;
                    end
                end
            end
            S_DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_kij_idx   = 4'd0;
                w_kij_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
        w_inst = {w_acc, w_cen_p, w_wen_p, w_a_p, w_cen_x, w_wen_x, w_a_x,
                  w_ofifo_rd, 1'b0, 1'b0, w_l0_rd, w_l0_wr, w_exec, w_load};
    end

    // State, counters and registered outputs; reset aborts straight to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_kij     <= 4'd0;
            r_k       <= 4'd0;
            r_kx      <= 4'd0;
            r_ky      <= 4'd0;
            r_o       <= 5'd0;
            r_ox      <= 4'd0;
            r_oy      <= 4'd0;
            r_inst    <= IDLE_WORD;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_kij_idx <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_kij     <= w_kij_nxt;
            r_k       <= w_k_nxt;
            r_kx      <= w_kx_nxt;
            r_ky      <= w_ky_nxt;
            r_o       <= w_o_nxt;
            r_ox      <= w_ox_nxt;
            r_oy      <= w_oy_nxt;
            r_inst    <= w_inst;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_kij_idx <= w_kij_idx;
        end
    end

    assign inst    = r_inst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign kij_idx = r_kij_idx;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: directed vector table, then whole layers
// replayed against a nested-loop model of the layer schedule.
module tb_conv_sequencer;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, valid;
    logic [33:0] inst;
    logic        busy, done;
    logic [3:0]  kij_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int pmem_wr  = 0;
    int bad_wen  = 0;

    conv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid),
        .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
    );

    always #5 clk = ~clk;

    // Count pmem writes, and writes not paired with an OFIFO pop.
    always @(negedge clk) begin
        if (inst[32] === 1'b0 && inst[31] === 1'b0) pmem_wr++;
        if (inst[31] === 1'b0 && inst[6] !== 1'b1) bad_wen++;
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic        v;
        logic [33:0] w;
        logic        b;
        logic        d;
        logic [3:0]  k;
    } vec_t;

    function automatic logic [33:0] mk(input logic acc, input logic cen_p, input logic wen_p,
                                       input logic [10:0] ap, input logic cen_x, input logic wen_x,
                                       input logic [10:0] ax, input logic ofifo_rd, input logic l0_rd,
                                       input logic l0_wr, input logic ex, input logic ld);
        return {acc, cen_p, wen_p, ap, cen_x, wen_x, ax, ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, ex, ld};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string nm, input logic [33:0] w, input logic b, input logic d,
                         input logic [3:0] k);
        n_checks++;
        if (inst !== w || busy !== b || done !== d || kij_idx !== k) begin
            n_fail++;
            $display("FAIL %s: got inst=%h busy=%b done=%b kij=%0d, want inst=%h busy=%b done=%b kij=%0d",
                     nm, inst, busy, done, kij_idx, w, b, d, k);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic st, input logic [33:0] w, input logic b,
                        input logic d, input logic [3:0] k, input string nm);
        valid = v;
        start = st;
        @(posedge clk);
        #1;
        check(nm, w, b, d, k);
    endtask

    // vmode: 0 valid held high, 1 valid toggles in drain phase, 2 random valid everywhere.
    task automatic run_layer(input int vmode, input logic junk, input int abort_kij);
        logic       v, ph;
        logic [3:0] kk;
        int         w, guard;
        step((vmode == 0) ? 1'b1 : 1'b0, 1'b1, IDLE_W, 1'b0, 1'b0, 4'd0, "start_accept");
        for (int kij = 0; kij < 9; kij++) begin
            kk = 4'(kij);
            for (int t = 0; t < 9; t++)
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(),
                     mk(1'b0, 1'b1, 1'b1, 11'd0, (t >= 8), 1'b1, (t < 8) ? 11'(128 + kij * 8 + t) : 11'd0,
                        1'b0, 1'b0, (t >= 1), 1'b0, 1'b0), 1'b1, 1'b0, kk, "w_rd");
            for (int t = 0; t < 8; t++)
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(),
                     mk(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1),
                     1'b1, 1'b0, kk, "w_ld");
            for (int t = 0; t < 16; t++)
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(), IDLE_W, 1'b1, 1'b0, kk, "w_drain");
            for (int t = 0; t < 37; t++)
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(),
                     mk(1'b0, 1'b1, 1'b1, 11'd0, (t >= 36), 1'b1, (t < 36) ? 11'(t) : 11'd0,
                        1'b0, 1'b0, (t >= 1), 1'b0, 1'b0), 1'b1, 1'b0, kk, "x_rd");
            for (int t = 0; t < 36; t++) begin
                if (kij == abort_kij && t == 10) return;
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(),
                     mk(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0),
                     1'b1, 1'b0, kk, "x_ex");
            end
            for (int t = 0; t < 16; t++)
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(), IDLE_W, 1'b1, 1'b0, kk, "x_drain");
            w = 0;
            ph = 1'b1;
            guard = 0;
            while (w < 36) begin
                v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ph : rbit();
                ph = ~ph;
                if (v) begin
                    step(1'b1, junk & rbit(),
                         mk(1'b0, 1'b0, 1'b0, 11'(kij * 36 + w), 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
                         1'b1, 1'b0, kk, "ps_wr");
                    w++;
                end else begin
                    step(1'b0, junk & rbit(), IDLE_W, 1'b1, 1'b0, kk, "ps_bubble");
                end
                guard++;
                if (guard > 400) begin
                    check_int("ps_wr_bound", guard, 36);
                    return;
                end
            end
        end
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 9; k++) begin
                step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(),
                     mk(1'b1, 1'b0, 1'b1, 11'(k * 36 + (o / 4) * 6 + (o % 4) + (k / 3) * 6 + (k % 3)),
                        1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 4'd8, "acc");
                if (o == 5 && k == 4) check_int("acc_o5_k4_addr", int'(inst[30:20]), 158);
            end
            step((vmode == 2) ? rbit() : (vmode == 0), junk & rbit(), IDLE_W, 1'b1, 1'b0, 4'd8, "acc_gap");
        end
        step(1'b0, junk & rbit(), IDLE_W, 1'b0, 1'b1, 4'd0, "done_pulse");
        step(1'b0, 1'b0, IDLE_W, 1'b0, 1'b0, 4'd0, "post_done_idle");
        start = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        vec_t vt[15];
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        vt[0]  = '{1'b1, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 34'h1_8004_4000,  1'b1, 1'b0, 4'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 34'h1_8004_4084,  1'b1, 1'b0, 4'd0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 34'h1_8004_4104,  1'b1, 1'b0, 4'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 34'h1_8004_4184,  1'b1, 1'b0, 4'd0};
        vt[10] = '{1'b1, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[12] = '{1'b0, 1'b1, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 34'h1_8004_4000,  1'b1, 1'b0, 4'd0};
        vt[14] = '{1'b1, 1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
        for (int i = 0; i < 15; i++) begin
            reset = vt[i].rst;
            start = vt[i].st;
            valid = vt[i].v;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vt[i].w, vt[i].b, vt[i].d, vt[i].k);
        end
        reset = 1'b0;

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, IDLE_W, 1'b0, 1'b0, 4'd0, "idle");

        pmem_wr = 0;
        bad_wen = 0;
        run_layer(0, 1'b0, -1);
        check_int("pmem_writes_layer_valid_high", pmem_wr, 324);

        pmem_wr = 0;
        run_layer(1, 1'b1, -1);
        check_int("pmem_writes_layer_toggle_junk_start", pmem_wr, 324);

        pmem_wr = 0;
        run_layer(2, 1'b0, 3);
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_abort", IDLE_W, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, IDLE_W, 1'b0, 1'b0, 4'd0, "idle_after_abort");
        check_int("pmem_writes_aborted", pmem_wr, 108);

        pmem_wr = 0;
        run_layer(2, 1'b1, -1);
        check_int("pmem_writes_layer_random", pmem_wr, 324);
        check_int("wen_without_ofifo_rd", bad_wen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
